dec_to_bin_parser: RTL and testbench
====================================

DEC_TO_BIN_PARSER -- requirements
Module: dec_to_bin_parser

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 16: output width in bits; a multiple of 4.
REQ-002 SHALL have parameter SEQ_DIGIT, default SEQ_LEN/4+1: character positions; SEQ_DIGIT-1 magnitude digits plus one sign position.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_char is valid.
REQ-006 SHALL have port in_char, input, 4 bits: character code.
REQ-007 SHALL have port in_ready, output, 1 bit: parser can accept a character.
REQ-008 SHALL have port value, output, SEQ_LEN bits: parsed two's-complement result, registered.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse; value is valid.
REQ-010 SHALL have port err, output, 1 bit: sticky syntax/overflow flag for the current entry.
REQ-011 SHALL have port digit_cnt, output, $clog2(SEQ_DIGIT)+1 bits: magnitude digits accepted so far.

Function
REQ-012 SHALL use these character codes: 0-9 = digit; 4'hA = minus sign (same code the font ROM renders as '-'); 4'hB = clear; 4'hF = enter; all others are invalid.
REQ-013 SHALL accept a character only on a cycle where in_valid && in_ready; no other cycle changes state.
REQ-014 SHALL implement states S_IDLE (no character yet), S_ACCUM (sign or at least one digit seen) and S_OUT (result presentation, one cycle).
REQ-015 SHALL drive in_ready = 1 in S_IDLE and S_ACCUM, and 0 in S_OUT.
REQ-016 SHALL, on a digit d accepted with digit_cnt < SEQ_DIGIT-1: mag <= mag*10 + d (computed as (mag<<3)+(mag<<1)+d, one cycle); digit_cnt increments; state becomes S_ACCUM.
REQ-017 SHALL, on a digit accepted with digit_cnt == SEQ_DIGIT-1: leave mag and digit_cnt unchanged and set err.
REQ-018 SHALL, on minus accepted in S_IDLE: set neg and go to S_ACCUM.
REQ-019 SHALL, on minus accepted in S_ACCUM: ignore the character and set err.
REQ-020 SHALL, on an invalid code accepted: ignore it and set err.
REQ-021 SHALL, on clear accepted in any state that has in_ready: zero mag, neg, digit_cnt and err, and go to S_IDLE.
REQ-022 SHALL, on enter accepted, at the next edge: register value = neg ? -mag : mag, enter S_OUT and raise out_valid.
REQ-023 SHALL hold out_valid high for exactly one cycle (S_OUT), then go to S_IDLE with mag, neg, digit_cnt and err cleared.
REQ-024 SHALL hold value until the next enter completes.
REQ-025 SHALL give latency of one cycle from enter acceptance to out_valid.
REQ-026 SHALL treat enter with zero digits (S_IDLE, or minus only) as value 0, with err unchanged.
REQ-027 SHALL produce value 0 for "-0", never a negative zero.
REQ-028 SHALL keep err asserted until S_OUT exits or clear is accepted.
REQ-029 SHALL keep mag within SEQ_LEN-1 bits: the SEQ_DIGIT-1 digit limit guarantees mag <= 10^(SEQ_DIGIT-1)-1 < 2^(SEQ_LEN-1) for SEQ_LEN in {8,16,32}, so no arithmetic overflow can occur.

Reset
REQ-030 SHALL, when rst is high at a clock edge: state = S_IDLE; value = 0; out_valid = 0; err = 0; digit_cnt = 0; mag = 0; neg = 0.
REQ-031 SHALL let rst override any simultaneous character acceptance.
REQ-032 SHALL, on reset during S_OUT, suppress the pending pulse (out_valid low on the next cycle).
REQ-033 SHALL drive in_ready = 1 on the first cycle after reset.

Structure
REQ-034 SHALL place character codes (CH_MINUS=4'hA, CH_CLEAR=4'hB, CH_ENTER=4'hF) and state encodings in a shared include file of localparams, used by this block and the font renderer.
REQ-035 SHALL implement the multiply-by-10-and-add datapath as sub-module mul10_add (combinational, SEQ_LEN-bit).
REQ-036 SHALL keep the state machine and registers in dec_to_bin_parser.

Verification
REQ-037 SHALL cover: SEQ_LEN=16, chars 1,2,3,4,F -> out_valid one cycle after F; value = 16'h04D2 (1234); err = 0.
REQ-038 SHALL cover: chars A,9,9,9,9,F -> value = 16'hD8F1 (-9999); err = 0.
REQ-039 SHALL cover: chars 1,2,3,4,5,F -> value = 1234; err = 1 during entry; digit_cnt saturates at 4.
REQ-040 SHALL cover: chars 5,A,7,F -> value = 57; err = 1; then B mid-entry -> digit_cnt = 0, err = 0.
REQ-041 SHALL cover: A,F -> value 0; F alone -> value 0; in_valid held high through S_OUT -> in_ready = 0 for that cycle and no character lost.
REQ-042 SHALL cover: rst asserted in the S_OUT cycle -> out_valid = 0 next cycle; loopback through the debug display path for random signed 16-bit values within +/-9999 -> value equals the original.

Source files
------------

// File: rtl/dec_to_bin_parser_pkg.sv
// Shared definitions for the decimal entry parser and the font renderer.
// Character codes presented on the 4-bit keypad/character bus, the parser
// state encoding, and a small classification helper.
package dec_to_bin_parser_pkg;

    localparam logic [3:0] CH_DIGIT_MAX = 4'h9;
    localparam logic [3:0] CH_MINUS     = 4'hA;  // rendered as '-' by the font ROM
    localparam logic [3:0] CH_CLEAR     = 4'hB;
    localparam logic [3:0] CH_ENTER     = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] c);
        return (c <= CH_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/dec_to_bin_parser_mul10_add.sv
// mul10_add: combinational result = mag*10 + digit, built from two shifts
// and an add so no multiplier is inferred.
// Ports:
//   mag    - current accumulated magnitude (W bits)
//   digit  - new decimal digit, 0..9
//   result - mag*10 + digit, truncated to W bits (caller bounds mag)
module mul10_add
    import dec_to_bin_parser_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] mag,
    input  logic [3:0]   digit,
    output logic [W-1:0] result
);

    assign result = (mag << 3) + (mag << 1) + {{(W-4){1'b0}}, digit};

endmodule

// File: rtl/dec_to_bin_parser.sv
// dec_to_bin_parser: accepts a stream of character codes (optional leading
// minus, up to SEQ_DIGIT-1 decimal digits, enter) and produces the signed
// two's-complement value with a one-cycle out_valid pulse.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid, in_char    - character handshake, accepted when in_ready is high
//   in_ready             - low only during the one-cycle result presentation
//   value, out_valid     - registered result and its one-cycle strobe
//   err                  - sticky syntax/overflow flag for the current entry
//   digit_cnt            - magnitude digits accepted so far
//
// state   | meaning
// S_IDLE  | nothing entered yet for this entry
// S_ACCUM | sign and/or at least one digit seen
// S_OUT   | result presented for one cycle, input stalled
module dec_to_bin_parser
    import dec_to_bin_parser_pkg::*;
#(
    parameter int SEQ_LEN   = 16,
    parameter int SEQ_DIGIT = SEQ_LEN / 4 + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [3:0]                     in_char,
    output logic                           in_ready,
    output logic [SEQ_LEN-1:0]             value,
    output logic                           out_valid,
    output logic                           err,
    output logic [$clog2(SEQ_DIGIT):0]     digit_cnt
);

    localparam int CNT_W = $clog2(SEQ_DIGIT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SEQ_DIGIT - 1);

    state_t             state;
    logic [SEQ_LEN-1:0] mag;
    logic [SEQ_LEN-1:0] mag_next;
    logic               neg;

    mul10_add #(.W(SEQ_LEN)) u_mul10_add (
        .mag    (mag),
        .digit  (in_char),
        .result (mag_next)
    );

    assign in_ready = (state != S_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            value     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            digit_cnt <= '0;
            mag       <= '0;
            neg       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_OUT: begin
                    state     <= S_IDLE;
                    mag       <= '0;
                    neg       <= 1'b0;
                    digit_cnt <= '0;
                    err       <= 1'b0;
                end
                default: begin
                    if (in_valid) begin
                        if (is_digit(in_char)) begin
                            // Digit limit keeps mag below 2^(SEQ_LEN-1), so no overflow.
                            if (digit_cnt < CNT_MAX) begin
                                mag       <= mag_next;
                                digit_cnt <= digit_cnt + 1'b1;
                                state     <= S_ACCUM;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            case (in_char)
                                CH_MINUS: begin
                                    if (state == S_IDLE) begin
                                        neg   <= 1'b1;
                                        state <= S_ACCUM;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                end
                                CH_CLEAR: begin
                                    mag       <= '0;
                                    neg       <= 1'b0;
                                    digit_cnt <= '0;
                                    err       <= 1'b0;
                                    state     <= S_IDLE;
                                end
                                CH_ENTER: begin
                                    // -0 negates to 0, so no negative zero is possible.
                                    value     <= neg ? -mag : mag;
                                    out_valid <= 1'b1;
                                    state     <= S_OUT;
                                end
                                default: err <= 1'b1;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_to_bin_parser.sv
module tb_dec_to_bin_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_char;
    logic        in_ready;
    logic [15:0] value;
    logic        out_valid;
    logic        err;
    logic [3:0]  digit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec_to_bin_parser #(.SEQ_LEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .value     (value),
        .out_valid (out_valid),
        .err       (err),
        .digit_cnt (digit_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one character for exactly one clock edge; returns #1 after the edge.
    task automatic send(input logic [3:0] c);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_char  = 4'h0;
    endtask

    // Enter, check the pulse and value, then let S_OUT expire.
    task automatic enter_and_check(input string tag, input logic [15:0] exp_val, input logic exp_err);
        send(4'hF);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_value"}, 32'(value), 32'(exp_val));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_inready_out"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_value_hold"}, 32'(value), 32'(exp_val));
    endtask

    initial begin
        int v;
        int m;
        logic [3:0] dg [4];
        int nd;

        // Reset with a character presented: reset must win.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_char  = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_inready", 32'(in_ready), 32'd1);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);

        // 1234
        send(4'h1); chk("p1_cnt1", 32'(digit_cnt), 32'd1);
        send(4'h2);
        send(4'h3);
        send(4'h4); chk("p1_cnt4", 32'(digit_cnt), 32'd4);
        chk("p1_no_early_pulse", 32'(out_valid), 32'd0);
        enter_and_check("p1", 16'h04D2, 1'b0);
        chk("p1_cnt_cleared", 32'(digit_cnt), 32'd0);

        // -9999
        send(4'hA); chk("p2_cnt_minus", 32'(digit_cnt), 32'd0);
        send(4'h9); send(4'h9); send(4'h9); send(4'h9);
        enter_and_check("p2", 16'hD8F1, 1'b0);

        // Fifth digit: saturates and flags error
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        chk("p3_err_before", 32'(err), 32'd0);
        send(4'h5);
        chk("p3_cnt_sat", 32'(digit_cnt), 32'd4);
        chk("p3_err", 32'(err), 32'd1);
        enter_and_check("p3", 16'd1234, 1'b1);
        chk("p3_err_cleared", 32'(err), 32'd0);

        // Late minus ignored
        send(4'h5); send(4'hA);
        chk("p4_err", 32'(err), 32'd1);
        send(4'h7);
        enter_and_check("p4", 16'd57, 1'b1);

        // Invalid code, then clear mid-entry
        send(4'h1); send(4'hC);
        chk("p5_inv_err", 32'(err), 32'd1);
        send(4'h2);
        chk("p5_cnt2", 32'(digit_cnt), 32'd2);
        send(4'hB);
        chk("p5_clr_cnt", 32'(digit_cnt), 32'd0);
        chk("p5_clr_err", 32'(err), 32'd0);
        enter_and_check("p5_f_alone", 16'd0, 1'b0);

        // Minus only, and -0
        send(4'h7);
        enter_and_check("p6_seven", 16'd7, 1'b0);
        send(4'hA);
        enter_and_check("p6_minus_only", 16'd0, 1'b0);
        send(4'h7);
        enter_and_check("p6_seven_b", 16'd7, 1'b0);
        send(4'hA); send(4'h0);
        enter_and_check("p6_neg_zero", 16'd0, 1'b0);

        // in_valid held through S_OUT: character must wait, not be lost
        send(4'h3);
        in_valid = 1'b1;
        in_char  = 4'hF;
        @(posedge clk);
        #1;
        in_char = 4'h8;
        chk("p7_ovalid", 32'(out_valid), 32'd1);
        chk("p7_value", 32'(value), 32'd3);
        chk("p7_inready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("p7_stall_cnt", 32'(digit_cnt), 32'd0);
        chk("p7_inready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("p7_char_taken", 32'(digit_cnt), 32'd1);
        enter_and_check("p7", 16'd8, 1'b0);

        // Reset in the S_OUT cycle
        send(4'h4); send(4'h2);
        send(4'hF);
        chk("p8_ovalid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("p8_rst_ovalid", 32'(out_valid), 32'd0);
        chk("p8_rst_value", 32'(value), 32'd0);
        chk("p8_rst_inready", 32'(in_ready), 32'd1);

        // Loopback: signed values rendered as characters and parsed back
        for (int k = 0; k < 10; k++) begin
            v = int'($urandom_range(0, 19998)) - 9999;
            m = (v < 0) ? -v : v;
            nd = 0;
            do begin
                dg[nd] = 4'(m % 10);
                m = m / 10;
                nd++;
            end while (m != 0);
            if (v < 0) send(4'hA);
            for (int j = nd - 1; j >= 0; j--) send(dg[j]);
            enter_and_check("loop", 16'(v), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
